// File: rtl/nv_buf_rr_arb.sv
// nv_buf_rr_arb
//   Round-robin arbiter in front of a shared datapath stage. At most one of
//   NREQ valid/ready requesters is granted per cycle. The granted payload and
//   its requester id are pushed into a 2-entry skid buffer, which drives a
//   single valid/ready consumer port.
//
// Ports
//   nvdla_core_clk  core clock, all state on the rising edge
//   nvdla_core_rst  asynchronous active-high reset
//   arb_en          1: grants allowed; 0: no new grants, buffer drains
//   req_pvld/prdy   per-requester handshake; req_prdy is one-hot or zero
//   req_pd          payloads, requester i at [i*DW +: DW]
//   dout_pvld/prdy  consumer handshake
//   dout_pd/id      head payload and the id of the requester that supplied it
//   arb_busy        buffer non-empty or any requester valid
module nv_buf_rr_arb #(
    parameter int NREQ = 4,
    parameter int DW   = 32,
    parameter int IDW  = 2
) (
    input  logic               nvdla_core_clk,
    input  logic               nvdla_core_rst,
    input  logic               arb_en,
    input  logic [NREQ-1:0]    req_pvld,
    output logic [NREQ-1:0]    req_prdy,
    input  logic [NREQ*DW-1:0] req_pd,
    output logic               dout_pvld,
    input  logic               dout_prdy,
    output logic [DW-1:0]      dout_pd,
    output logic [IDW-1:0]     dout_id,
    output logic               arb_busy
);

    logic [1:0]     cnt_q, cnt_d;
    logic [IDW-1:0] rr_ptr_q, rr_ptr_d;
    logic           vld_q, vld_d;
    logic [DW-1:0]  hd_pd_q, hd_pd_d, tl_pd_q, tl_pd_d;
    logic [IDW-1:0] hd_id_q, hd_id_d, tl_id_q, tl_id_d;

    logic           can_acc;
    logic           gnt_vld;
    logic [IDW-1:0] gnt_id;
    logic [DW-1:0]  gnt_pd;
    logic           xfer;
    logic           pop;

    // Requester visited k steps after the round-robin pointer.
    function automatic logic [IDW-1:0] rr_idx(input logic [IDW-1:0] ptr, input int k);
        return IDW'((int'(ptr) + k) % NREQ);
    endfunction

    // Accepting never looks at dout_prdy, so there is no combinational
    // path from the consumer back to the requesters.
    assign can_acc = (cnt_q != 2'd2) & arb_en;

    always_comb begin
        gnt_vld = 1'b0;
        gnt_id  = '0;
        for (int k = 0; k < NREQ; k++) begin
            if (!gnt_vld && req_pvld[rr_idx(rr_ptr_q, k)]) begin
                gnt_vld = 1'b1;
                gnt_id  = rr_idx(rr_ptr_q, k);
            end
        end
    end

    assign xfer   = can_acc & gnt_vld;
    assign pop    = vld_q & dout_prdy;
    assign gnt_pd = req_pd[int'(gnt_id)*DW +: DW];

    always_comb begin
        req_prdy = '0;
        for (int i = 0; i < NREQ; i++) begin
            req_prdy[i] = xfer && (gnt_id == IDW'(i));
        end
    end

    // Pointer moves just past the winner, so a skipped requester keeps
    // its place in line.
    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (xfer) begin
            rr_ptr_d = (gnt_id == IDW'(NREQ-1)) ? '0 : gnt_id + IDW'(1);
        end
    end

    // Buffer: head registers drive the outputs directly; tail holds the
    // second entry when cnt=2.
    always_comb begin
        cnt_d   = cnt_q;
        hd_pd_d = hd_pd_q;
        hd_id_d = hd_id_q;
        tl_pd_d = tl_pd_q;
        tl_id_d = tl_id_q;
        case ({xfer, pop})
            2'b10: begin
                cnt_d = cnt_q + 2'd1;
                if (cnt_q == 2'd0) begin
                    hd_pd_d = gnt_pd;
                    hd_id_d = gnt_id;
                end else begin
                    tl_pd_d = gnt_pd;
                    tl_id_d = gnt_id;
                end
            end
            2'b01: begin
                cnt_d = cnt_q - 2'd1;
                if (cnt_q == 2'd2) begin
                    hd_pd_d = tl_pd_q;
                    hd_id_d = tl_id_q;
                end
            end
            2'b11: begin
                // Push needs cnt<2 and pop needs cnt>0, so cnt is 1 here:
                // the new entry replaces the departing head.
                hd_pd_d = gnt_pd;
                hd_id_d = gnt_id;
            end
            default: ;
        endcase
        vld_d = (cnt_d != 2'd0);
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            cnt_q    <= '0;
            rr_ptr_q <= '0;
            vld_q    <= 1'b0;
            hd_pd_q  <= '0;
            hd_id_q  <= '0;
            tl_pd_q  <= '0;
            tl_id_q  <= '0;
        end else begin
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
            vld_q    <= vld_d;
            hd_pd_q  <= hd_pd_d;
            hd_id_q  <= hd_id_d;
            tl_pd_q  <= tl_pd_d;
            tl_id_q  <= tl_id_d;
        end
    end

    assign dout_pvld = vld_q;
    assign dout_pd   = hd_pd_q;
    assign dout_id   = hd_id_q;
    assign arb_busy  = (cnt_q != 2'd0) | (|req_pvld);

endmodule

// File: tb/tb_nv_buf_rr_arb.sv
module tb_nv_buf_rr_arb;
    localparam int NREQ = 4;
    localparam int DW   = 32;
    localparam int IDW  = 2;

    logic               clk = 1'b0;
    logic               rst;
    logic               arb_en;
    logic [NREQ-1:0]    req_pvld;
    logic [NREQ-1:0]    req_prdy;
    logic [NREQ*DW-1:0] req_pd;
    logic               dout_pvld;
    logic               dout_prdy;
    logic [DW-1:0]      dout_pd;
    logic [IDW-1:0]     dout_id;
    logic               arb_busy;

    nv_buf_rr_arb #(.NREQ(NREQ), .DW(DW), .IDW(IDW)) dut (
        .nvdla_core_clk(clk),
        .nvdla_core_rst(rst),
        .arb_en(arb_en),
        .req_pvld(req_pvld),
        .req_prdy(req_prdy),
        .req_pd(req_pd),
        .dout_pvld(dout_pvld),
        .dout_prdy(dout_prdy),
        .dout_pd(dout_pd),
        .dout_id(dout_id),
        .arb_busy(arb_busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int          id;
        logic [31:0] pd;
    } ent_t;

    ent_t mq[$];   // model buffer, head at index 0
    int   mptr;    // model round-robin pointer

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h t=%0t", nm, act, exp, $time);
        end
    endtask

    // First valid requester at or after the pointer, -1 if no grant.
    function automatic int m_grant();
        int g = -1;
        if (arb_en && mq.size() < 2) begin
            for (int k = 0; k < NREQ; k++) begin
                if (g < 0 && req_pvld[(mptr + k) % NREQ]) g = (mptr + k) % NREQ;
            end
        end
        return g;
    endfunction

    task automatic check_model();
        int g;
        logic [NREQ-1:0] ep;
        if (rst) begin
            mq.delete();
            mptr = 0;
        end
        g  = m_grant();
        ep = '0;
        if (g >= 0) ep[g] = 1'b1;
        chk("req_prdy", 64'(req_prdy), 64'(ep));
        chk("dout_pvld", 64'(dout_pvld), 64'(mq.size() != 0));
        if (rst) begin
            chk("rst_pd", 64'(dout_pd), 64'd0);
            chk("rst_id", 64'(dout_id), 64'd0);
        end else if (mq.size() != 0) begin
            chk("dout_pd", 64'(dout_pd), 64'(mq[0].pd));
            chk("dout_id", 64'(dout_id), 64'(mq[0].id));
        end
        chk("arb_busy", 64'(arb_busy), 64'((mq.size() != 0) || (req_pvld != 0)));
    endtask

    task automatic model_step();
        int g;
        ent_t e;
        if (!rst) begin
            g = m_grant();
            if (mq.size() != 0 && dout_prdy) void'(mq.pop_front());
            if (g >= 0) begin
                e.id = g;
                e.pd = req_pd[g*DW +: DW];
                mq.push_back(e);
                mptr = (g + 1) % NREQ;
            end
        end
    endtask

    // Called at a negedge with inputs already applied.
    task automatic cyc();
        #1;
        check_model();
        @(posedge clk);
        model_step();
        @(negedge clk);
    endtask

    initial begin
        mptr      = 0;
        rst       = 1'b1;
        arb_en    = 1'b1;
        req_pvld  = '0;
        req_pd    = '0;
        dout_prdy = 1'b1;
        @(negedge clk);
        cyc();
        #1;
        chk("reset_pvld", 64'(dout_pvld), 64'd0);
        chk("reset_pd", 64'(dout_pd), 64'd0);
        chk("reset_id", 64'(dout_id), 64'd0);
        cyc();
        rst = 1'b0;

        // single requester, one-cycle latency
        req_pvld = 4'b0001;
        req_pd[0 +: DW] = 32'hA5;
        #1 chk("t1_prdy", 64'(req_prdy), 64'h1);
        cyc();
        req_pvld = 4'b0000;
        #1;
        chk("t1_pvld", 64'(dout_pvld), 64'd1);
        chk("t1_pd", 64'(dout_pd), 64'hA5);
        chk("t1_id", 64'(dout_id), 64'd0);
        cyc();

        // all valid, consumer ready: 0,1,2,3,0,1 with id lagging by one
        rst = 1'b1; cyc(); rst = 1'b0;
        req_pvld = 4'b1111;
        for (int n = 0; n < 6; n++) begin
            #1;
            chk("t2_prdy", 64'(req_prdy), 64'(1 << (n % 4)));
            if (n > 0) chk("t2_id", 64'((n - 1) % 4), 64'(dout_id));
            cyc();
        end

        // consumer stalled: exactly two grants, then drain and resume at 2
        rst = 1'b1; cyc(); rst = 1'b0;
        dout_prdy = 1'b0;
        #1 chk("t3_g0", 64'(req_prdy), 64'b0001);
        cyc();
        #1 chk("t3_g1", 64'(req_prdy), 64'b0010);
        cyc();
        #1 chk("t3_full", 64'(req_prdy), 64'b0000);
        cyc();
        #1 chk("t3_full2", 64'(req_prdy), 64'b0000);
        cyc();
        dout_prdy = 1'b1;
        #1;
        chk("t3_pop0", 64'(dout_id), 64'd0);
        chk("t3_noacc", 64'(req_prdy), 64'b0000);
        cyc();
        #1;
        chk("t3_pop1", 64'(dout_id), 64'd1);
        chk("t3_next2", 64'(req_prdy), 64'b0100);
        dout_prdy = 1'b0;
        cyc();

        // alternating requesters 1 and 3 from pointer 0
        rst = 1'b1; cyc(); rst = 1'b0;
        dout_prdy = 1'b1;
        req_pvld = 4'b1010;
        #1 chk("t4_g1", 64'(req_prdy), 64'b0010);
        cyc();
        #1 chk("t4_g3", 64'(req_prdy), 64'b1000);
        cyc();
        #1 chk("t4_g1b", 64'(req_prdy), 64'b0010);
        cyc();

        // arb_en low with full buffer: no grants, entries drain
        req_pvld = 4'b1111;
        dout_prdy = 1'b0;
        cyc();
        cyc();
        arb_en = 1'b0;
        #1;
        chk("t5_prdy", 64'(req_prdy), 64'd0);
        chk("t5_busy", 64'(arb_busy), 64'd1);
        dout_prdy = 1'b1;
        cyc();
        cyc();
        #1;
        chk("t5_empty", 64'(dout_pvld), 64'd0);
        chk("t5_busy2", 64'(arb_busy), 64'd1);
        chk("t5_prdy2", 64'(req_prdy), 64'd0);
        cyc();

        // async reset while full
        arb_en = 1'b1;
        dout_prdy = 1'b0;
        cyc();
        cyc();
        #2;
        rst = 1'b1;
        #1;
        chk("t6_pvld", 64'(dout_pvld), 64'd0);
        chk("t6_pd", 64'(dout_pd), 64'd0);
        chk("t6_id", 64'(dout_id), 64'd0);
        cyc();
        rst = 1'b0;
        #1 chk("t6_first", 64'(req_prdy), 64'b0001);
        cyc();

        // randomized traffic against the model
        for (int n = 0; n < 3000; n++) begin
            arb_en    = ($urandom % 10) != 0;
            req_pvld  = NREQ'($urandom);
            dout_prdy = ($urandom % 4) != 0;
            rst       = ($urandom % 300) == 0;
            for (int i = 0; i < NREQ; i++) req_pd[i*DW +: DW] = $urandom;
            cyc();
        end
        rst = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
